// File: rtl/jtvigil_bank_arb.sv
// jtvigil_bank_arb: shares one SDRAM bank among SLOTS ROM read slots.
// Each slot keeps a one-entry cache (valid, tag, data). Misses are
// serviced one at a time with round-robin priority through a
// REQ/DATA handshake on the bank port.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   downloading       ROM load in progress; invalidates every cache entry
//   slot_cs/addr      per-slot read request and address (slot 0 in LSBs)
//   slot_data/ok      per-slot cached data and hit indication
//   ba_addr/ba_rd     SDRAM word address and read request
//   ba_ack            request accepted (one cycle)
//   ba_dok/data_read  valid 16-bit read word
//   ba_rdy            transfer finished (one cycle)
module jtvigil_bank_arb #(
  parameter int unsigned         SLOTS  = 4,
  parameter int unsigned         AW     = 18,
  parameter int unsigned         DW     = 32,
  parameter logic [SLOTS*22-1:0] OFFSET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS*DW-1:0] slot_data,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [21:0]         ba_addr,
  output logic                ba_rd,
  input  logic                ba_ack,
  input  logic                ba_dok,
  input  logic                ba_rdy,
  input  logic [15:0]         data_read
);

  // Byte-wide slots still cache a whole 16-bit SDRAM word.
  localparam int unsigned CW = (DW == 32) ? 32 : 16;
  localparam int unsigned GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ba_rd_q, ba_rd_d;
  logic [21:0]       ba_addr_q, ba_addr_d;
  logic [AW-1:0]     tagbuf_q, tagbuf_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [CW-1:0]     buf_q, buf_d;
  logic              wcnt_q, wcnt_d;
  logic              dlseen_q, dlseen_d;

  logic [SLOTS-1:0]  valid_q;
  logic [AW-1:0]     tag_q  [SLOTS];
  logic [CW-1:0]     data_q [SLOTS];

  logic [SLOTS-1:0]  hit;
  logic [SLOTS-1:0]  pending;
  logic              found;
  logic [GW-1:0]     gsel;
  logic [AW-1:0]     sel_addr;
  logic [21:0]       sel_off;
  int unsigned       rr_idx;

  logic              fill_we;
  logic              fill_valid;
  logic [CW-1:0]     fill_data;

  // Slot address in slot data units to SDRAM 16-bit word address.
  function automatic logic [21:0] word_addr(input logic [AW-1:0] a);
    logic [AW:0] ext;
    ext = {1'b0, a};
    if (DW == 8)       return 22'(ext >> 1);
    else if (DW == 16) return 22'(ext);
    else               return 22'(ext << 1);
  endfunction

  // Per-slot hit detection and read-data steering from the cache.
  for (genvar i = 0; i < int'(SLOTS); i++) begin : g_slot
    logic [AW-1:0] addr_w;
    assign addr_w = slot_addr[i*AW +: AW];
    if (DW == 8) begin : g_byte
      assign hit[i] = valid_q[i] && (tag_q[i][AW-1:1] == addr_w[AW-1:1]);
      assign slot_data[i*DW +: DW] = addr_w[0] ? data_q[i][15:8] : data_q[i][7:0];
    end else begin : g_word
      assign hit[i] = valid_q[i] && (tag_q[i] == addr_w);
      assign slot_data[i*DW +: DW] = data_q[i][DW-1:0];
    end
    assign slot_ok[i] = slot_cs[i] & hit[i];
  end

  assign ba_rd   = ba_rd_q;
  assign ba_addr = ba_addr_q;

  // Round-robin pick of the first missing slot after the last one served.
  always_comb begin
    pending  = slot_cs & ~hit & {SLOTS{~downloading}};
    found    = 1'b0;
    gsel     = '0;
    sel_addr = '0;
    sel_off  = '0;
    rr_idx   = 0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      rr_idx = (32'(last_q) + k) % SLOTS;
      if (!found && pending[GW'(rr_idx)]) begin
        found    = 1'b1;
        gsel     = GW'(rr_idx);
        sel_addr = slot_addr[rr_idx*AW +: AW];
        sel_off  = OFFSET[rr_idx*22 +: 22];
      end
    end
  end

  // Next-state and bank-port control.
  always_comb begin
    state_d    = state_q;
    ba_rd_d    = ba_rd_q;
    ba_addr_d  = ba_addr_q;
    tagbuf_d   = tagbuf_q;
    grant_d    = grant_q;
    last_d     = last_q;
    buf_d      = buf_q;
    wcnt_d     = wcnt_q;
    dlseen_d   = dlseen_q | downloading;
    fill_we    = 1'b0;
    fill_valid = 1'b0;
    fill_data  = buf_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = REQ;
          ba_rd_d   = 1'b1;
          ba_addr_d = sel_off + word_addr(sel_addr);
          tagbuf_d  = sel_addr;
          grant_d   = gsel;
          buf_d     = '0;
          wcnt_d    = 1'b0;
          dlseen_d  = 1'b0;
        end
      end
      REQ: begin
        if (ba_ack) begin
          state_d = DATA;
          ba_rd_d = 1'b0;
        end
      end
      DATA: begin
        // First word lands in the low half; only 32-bit slots take a second.
        if (ba_dok) begin
          if (!wcnt_q) begin
            fill_data = CW'(data_read);
            wcnt_d    = 1'b1;
          end else if (CW == 32) begin
            fill_data = CW'({data_read, buf_q[15:0]});
          end
        end
        buf_d = fill_data;
        if (ba_rdy) begin
          // A download seen during the transfer makes the fetched data stale.
          fill_we    = 1'b1;
          fill_valid = !dlseen_q && !downloading;
          last_d     = grant_q;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ba_rd_d = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ba_rd_q   <= 1'b0;
      ba_addr_q <= '0;
      tagbuf_q  <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      buf_q     <= '0;
      wcnt_q    <= 1'b0;
      dlseen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ba_rd_q   <= ba_rd_d;
      ba_addr_q <= ba_addr_d;
      tagbuf_q  <= tagbuf_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      buf_q     <= buf_d;
      wcnt_q    <= wcnt_d;
      dlseen_q  <= dlseen_d;
    end
  end

  // Cache entries; downloading overrides any fill in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fill_we) begin
        valid_q[grant_q] <= fill_valid;
        tag_q[grant_q]   <= tagbuf_q;
        data_q[grant_q]  <= fill_data;
      end
      if (downloading) valid_q <= '0;
    end
  end

endmodule

// File: tb/tb_jtvigil_bank_arb.sv
// Directed bench for jtvigil_bank_arb: a 4-slot 32-bit instance and a
// 1-slot 8-bit instance share clock, reset and downloading.
module tb_jtvigil_bank_arb;

  logic clk;
  logic rst;
  logic dl;

  logic [3:0]   cs;
  logic [71:0]  addr;
  logic [127:0] sdata;
  logic [3:0]   ok;
  logic [21:0]  ba_addr;
  logic         ba_rd, ack, dok, rdy;
  logic [15:0]  rd_data;

  logic         cs8;
  logic [17:0]  addr8;
  logic [7:0]   sdata8;
  logic         ok8;
  logic [21:0]  ba_addr8;
  logic         ba_rd8, ack8, dok8, rdy8;
  logic [15:0]  rd8;

  int n_checks;
  int n_fail;

  jtvigil_bank_arb #(
    .SLOTS (4), .AW(18), .DW(32),
    .OFFSET({22'h030000, 22'h020000, 22'h010000, 22'h008000})
  ) dut32 (
    .clk(clk), .rst(rst), .downloading(dl),
    .slot_cs(cs), .slot_addr(addr), .slot_data(sdata), .slot_ok(ok),
    .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ack), .ba_dok(dok),
    .ba_rdy(rdy), .data_read(rd_data)
  );

  jtvigil_bank_arb #(
    .SLOTS (1), .AW(18), .DW(8), .OFFSET(22'h001000)
  ) dut8 (
    .clk(clk), .rst(rst), .downloading(dl),
    .slot_cs(cs8), .slot_addr(addr8), .slot_data(sdata8), .slot_ok(ok8),
    .ba_addr(ba_addr8), .ba_rd(ba_rd8), .ba_ack(ack8), .ba_dok(dok8),
    .ba_rdy(rdy8), .data_read(rd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_addr(input int i, input logic [17:0] a);
    addr[i*18 +: 18] = a;
  endtask

  // Bank model for the 32-bit instance: waits for ba_rd, acks, returns two words.
  task automatic serve32(input logic [15:0] w0, input logic [15:0] w1,
                         output bit got, output logic [21:0] a);
    got = 1'b0;
    a   = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ba_rd) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) return;
    a   = ba_addr;
    ack = 1'b1;
    @(negedge clk);
    ack     = 1'b0;
    dok     = 1'b1;
    rd_data = w0;
    @(negedge clk);
    rd_data = w1;
    rdy     = 1'b1;
    @(negedge clk);
    dok = 1'b0;
    rdy = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; dl = 1'b0;
    cs = '0; addr = '0; ack = 0; dok = 0; rdy = 0; rd_data = '0;
    cs8 = 0; addr8 = '0; ack8 = 0; dok8 = 0; rdy8 = 0; rd8 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ba_rd !== 1'b0 || ba_addr !== 22'h0) begin
      n_fail++; $display("FAIL reset_bank: rd=%b addr=%h required 0/0", ba_rd, ba_addr);
    end
    n_checks++;
    if (ok !== 4'h0 || sdata !== 128'h0) begin
      n_fail++; $display("FAIL reset_slots: ok=%b data=%h required 0", ok, sdata);
    end
    n_checks++;
    if (ba_rd8 !== 1'b0 || ok8 !== 1'b0 || sdata8 !== 8'h0) begin
      n_fail++; $display("FAIL reset_dw8: rd=%b ok=%b data=%h required 0", ba_rd8, ok8, sdata8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit got; logic [21:0] a;
    cs = 4'b0001;
    set_addr(0, 18'h100);
    #1;
    n_checks++;
    if (ok[0] !== 1'b0) begin
      n_fail++; $display("FAIL basic_miss_ok: ok0=%b required 0", ok[0]);
    end
    serve32(16'h1234, 16'hABCD, got, a);
    n_checks++;
    if (!got || a !== 22'h008200) begin
      n_fail++; $display("FAIL basic_addr: got=%0d addr=%h required 008200", got, a);
    end
    n_checks++;
    if (ok[0] !== 1'b1 || sdata[31:0] !== 32'hABCD1234) begin
      n_fail++; $display("FAIL basic_fill: ok0=%b data=%h required 1/abcd1234", ok[0], sdata[31:0]);
    end
  endtask

  task automatic test_hit;
    bit rd_seen;
    cs = 4'b0000;
    #1;
    n_checks++;
    if (ok[0] !== 1'b0) begin
      n_fail++; $display("FAIL hit_cs_low: ok0=%b required 0", ok[0]);
    end
    cs = 4'b0001;
    #1;
    n_checks++;
    if (ok[0] !== 1'b1 || sdata[31:0] !== 32'hABCD1234) begin
      n_fail++; $display("FAIL hit_same_cycle: ok0=%b data=%h required 1/abcd1234", ok[0], sdata[31:0]);
    end
    set_addr(0, 18'h101);
    #1;
    n_checks++;
    if (ok[0] !== 1'b0) begin
      n_fail++; $display("FAIL hit_addr_change: ok0=%b required 0", ok[0]);
    end
    set_addr(0, 18'h100);
    rd_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ba_rd) rd_seen = 1'b1;
    end
    n_checks++;
    if (rd_seen !== 1'b0) begin
      n_fail++; $display("FAIL hit_no_rd: rd_seen=%b required 0", rd_seen);
    end
  endtask

  task automatic test_round_robin;
    bit got; logic [21:0] a;
    logic [21:0] exp1 [4];
    logic [21:0] exp2 [4];
    exp1 = '{22'h008020, 22'h010040, 22'h020060, 22'h030080};
    exp2 = '{22'h020062, 22'h030082, 22'h008022, 22'h010044};
    cs  = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 18'((i + 1) * 16));
    cs = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve32(16'(k), 16'h1000, got, a);
      n_checks++;
      if (!got || a !== exp1[k]) begin
        n_fail++; $display("FAIL rr_first_%0d: got=%0d addr=%h required %h", k, got, a, exp1[k]);
      end
    end
    n_checks++;
    if (ok !== 4'b1111) begin
      n_fail++; $display("FAIL rr_all_ok: ok=%b required 1111", ok);
    end
    cs = 4'b0010;
    set_addr(1, 18'h021);
    serve32(16'h0111, 16'h0222, got, a);
    n_checks++;
    if (!got || a !== 22'h010042) begin
      n_fail++; $display("FAIL rr_slot1_alone: got=%0d addr=%h required 010042", got, a);
    end
    set_addr(0, 18'h011); set_addr(1, 18'h022);
    set_addr(2, 18'h031); set_addr(3, 18'h041);
    cs = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      serve32(16'(k), 16'h2000, got, a);
      n_checks++;
      if (!got || a !== exp2[k]) begin
        n_fail++; $display("FAIL rr_second_%0d: got=%0d addr=%h required %h", k, got, a, exp2[k]);
      end
    end
  endtask

  task automatic test_midchange;
    bit got; logic [21:0] a;
    cs = 4'b0100;
    set_addr(2, 18'h050);
    @(negedge clk);
    set_addr(2, 18'h077);
    cs = 4'b0000;
    serve32(16'h5566, 16'h7788, got, a);
    n_checks++;
    if (!got || a !== 22'h0200A0) begin
      n_fail++; $display("FAIL mid_addr: got=%0d addr=%h required 0200a0", got, a);
    end
    set_addr(2, 18'h050);
    cs = 4'b0100;
    #1;
    n_checks++;
    if (ok[2] !== 1'b1 || sdata[95:64] !== 32'h77885566) begin
      n_fail++; $display("FAIL mid_fill: ok2=%b data=%h required 1/77885566", ok[2], sdata[95:64]);
    end
  endtask

  task automatic test_download;
    bit got; logic [21:0] a;
    set_addr(0, 18'h011); set_addr(1, 18'h022);
    set_addr(2, 18'h050); set_addr(3, 18'h041);
    cs = 4'b1111;
    #1;
    n_checks++;
    if (ok !== 4'b1111) begin
      n_fail++; $display("FAIL dl_before: ok=%b required 1111", ok);
    end
    dl = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ok !== 4'b0000 || ba_rd !== 1'b0) begin
      n_fail++; $display("FAIL dl_clear: ok=%b rd=%b required 0000/0", ok, ba_rd);
    end
    cs = 4'b0001;
    dl = 1'b0;
    serve32(16'h4321, 16'h8765, got, a);
    n_checks++;
    if (!got || a !== 22'h008022 || ok[0] !== 1'b1 || sdata[31:0] !== 32'h87654321) begin
      n_fail++; $display("FAIL dl_refetch: got=%0d addr=%h ok0=%b data=%h required 008022/1/87654321",
                         got, a, ok[0], sdata[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    bit got; logic [21:0] a;
    got = 1'b0;
    cs = 4'b0011;
    set_addr(1, 18'h060);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ba_rd) got = 1'b1;
    end
    n_checks++;
    if (!got || ok[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_req: rd=%0d ok0=%b required 1/1", got, ok[0]);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; dok = 1'b1; rd_data = 16'hBEEF;
    @(negedge clk);
    dok = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ba_rd !== 1'b0 || ok !== 4'b0000 || ba_addr !== 22'h0) begin
      n_fail++; $display("FAIL rstmid_immediate: rd=%b ok=%b addr=%h required 0", ba_rd, ok, ba_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    cs  = 4'b0000;
    dok = 1'b1; rdy = 1'b1; rd_data = 16'hDEAD;
    @(negedge clk);
    dok = 1'b0; rdy = 1'b0;
    cs = 4'b0010;
    #1;
    n_checks++;
    if (ok[1] !== 1'b0 || ba_rd !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_write: ok1=%b rd=%b required 0/0", ok[1], ba_rd);
    end
    serve32(16'h0A0B, 16'h0C0D, got, a);
    n_checks++;
    if (!got || a !== 22'h0100C0 || sdata[63:32] !== 32'h0C0D0A0B) begin
      n_fail++; $display("FAIL rstmid_refetch: got=%0d addr=%h data=%h required 0100c0/0c0d0a0b",
                         got, a, sdata[63:32]);
    end
    cs = '0;
  endtask

  task automatic test_dw8;
    bit got; bit rd_seen;
    cs8 = 1'b1; addr8 = 18'h020;
    #1;
    n_checks++;
    if (ok8 !== 1'b0) begin
      n_fail++; $display("FAIL dw8_miss: ok=%b required 0", ok8);
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ba_rd8) got = 1'b1;
    end
    n_checks++;
    if (!got || ba_addr8 !== 22'h001010) begin
      n_fail++; $display("FAIL dw8_addr: rd=%0d addr=%h required 001010", got, ba_addr8);
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0; dok8 = 1'b1; rd8 = 16'h5A3C;
    @(negedge clk);
    rd8 = 16'hFFFF; rdy8 = 1'b1;
    @(negedge clk);
    dok8 = 1'b0; rdy8 = 1'b0;
    n_checks++;
    if (ok8 !== 1'b1 || sdata8 !== 8'h3C) begin
      n_fail++; $display("FAIL dw8_fill: ok=%b data=%h required 1/3c", ok8, sdata8);
    end
    addr8 = 18'h021;
    #1;
    n_checks++;
    if (ok8 !== 1'b1 || sdata8 !== 8'h5A) begin
      n_fail++; $display("FAIL dw8_odd_hit: ok=%b data=%h required 1/5a", ok8, sdata8);
    end
    rd_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ba_rd8) rd_seen = 1'b1;
    end
    addr8 = 18'h020;
    #1;
    n_checks++;
    if (rd_seen !== 1'b0 || sdata8 !== 8'h3C) begin
      n_fail++; $display("FAIL dw8_even: rd_seen=%b data=%h required 0/3c", rd_seen, sdata8);
    end
    addr8 = 18'h023;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ba_rd8) got = 1'b1;
    end
    n_checks++;
    if (!got || ba_addr8 !== 22'h001011) begin
      n_fail++; $display("FAIL dw8_addr2: rd=%0d addr=%h required 001011", got, ba_addr8);
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0; dok8 = 1'b1; rdy8 = 1'b1; rd8 = 16'h7788;
    @(negedge clk);
    dok8 = 1'b0; rdy8 = 1'b0;
    n_checks++;
    if (ok8 !== 1'b1 || sdata8 !== 8'h77) begin
      n_fail++; $display("FAIL dw8_dok_rdy: ok=%b data=%h required 1/77", ok8, sdata8);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_hit();
    test_round_robin();
    test_midchange();
    test_download();
    test_reset_mid();
    test_dw8();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtvigil_bank_arb.md
JTVIGIL_BANK_ARB -- requirements
Module: jtvigil_bank_arb

Interface
REQ-001 Parameter SLOTS, default 4, number of ROM read slots sharing one SDRAM bank (legal 1..8).
REQ-002 Parameter AW, default 18, slot address width in slot data units.
REQ-003 Parameter DW, default 32, slot data width; legal 8, 16, 32.
REQ-004 Parameter OFFSET, default 0, packed SLOTS*22 bits of per-slot 16-bit-word base address in the bank.
REQ-005 Port clk, input, 1, sole clock; all state on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port downloading, input, 1, high while ROM load runs; invalidates caches.
REQ-008 Port slot_cs, input, SLOTS, per-slot read request.
REQ-009 Port slot_addr, input, SLOTS*AW, packed slot addresses (slot 0 in LSBs).
REQ-010 Port slot_data, output, SLOTS*DW, packed cached data per slot.
REQ-011 Port slot_ok, output, SLOTS, slot_data valid for current slot_addr.
REQ-012 Port ba_addr, output, 22, SDRAM word address.
REQ-013 Port ba_rd, output, 1, SDRAM read request.
REQ-014 Port ba_ack, input, 1, one-cycle request acceptance.
REQ-015 Port ba_dok, input, 1, data_read holds a valid 16-bit word this cycle.
REQ-016 Port ba_rdy, input, 1, one-cycle end of transfer.
REQ-017 Port data_read, input, 16, SDRAM read data.

Function
REQ-018 Each slot SHALL own a cache entry: valid bit, tag (AW bits), data (DW bits, 16 bits for DW=8).
REQ-019 Hit SHALL mean valid && tag == slot_addr, except DW=8 compares slot_addr[AW-1:1] against tag[AW-1:1].
REQ-020 slot_ok[i] SHALL equal slot_cs[i] && hit[i], combinational from registered cache; drops same cycle cs falls or address changes.
REQ-021 slot_data SHALL be cache data; DW=8 selects byte by slot_addr[0] (0 = low byte); DW=16/32 full entry.
REQ-022 Word address SHALL be: DW=8 addr>>1; DW=16 addr; DW=32 addr<<1; ba_addr = OFFSET[i] + word address, truncated to 22 bits.
REQ-023 FSM states IDLE, REQ, DATA; reset state IDLE.
REQ-024 IDLE: pending = slot_cs & ~hit & {SLOTS{~downloading}}; if nonzero, grant first pending slot round-robin starting at last_grant+1 (mod SLOTS), latch its address into tag buffer, drive ba_addr, go REQ next cycle.
REQ-025 REQ: ba_rd SHALL be high, ba_addr stable; on ba_ack go DATA and drop ba_rd next cycle.
REQ-026 DATA: each ba_dok stores data_read; DW=32 first dok -> bits 15:0, second -> 31:16; DW=8/16 first dok -> bits 15:0, further doks ignored.
REQ-027 DATA: on ba_rdy write latched tag and captured data into granted slot entry, set valid, update last_grant, return IDLE; slot_ok high next cycle if cs and address still match.
REQ-028 ba_dok and ba_rdy in the same cycle SHALL store the word and then complete.
REQ-029 Granted slot's cs falling or address changing mid-transfer SHALL NOT abort; entry fills with the latched address.
REQ-030 downloading high SHALL clear all valid bits every cycle; an in-flight transfer completes but does not set valid.
REQ-031 Minimum miss latency: cs rise to slot_ok = 3 cycles + SDRAM ack/data latency.
REQ-032 SLOTS=1 SHALL work with the round-robin pointer fixed at 0.

Reset
REQ-033 rst high SHALL force immediately: state IDLE, ba_rd 0, ba_addr 0, all valid 0, slot_ok 0, slot_data 0, last_grant SLOTS-1.
REQ-034 Reset mid-transfer SHALL abandon it; subsequent ba_dok/ba_rdy in IDLE SHALL be ignored.

Verification
REQ-035 DW=32, slot 0 cs, addr 0x100, OFFSET0=0x8000 -> ba_rd with ba_addr 0x8200; doks 0x1234, 0xABCD -> slot_data0 0xABCD1234, slot_ok0 next cycle after rdy.
REQ-036 Repeat same address -> slot_ok0 same cycle as cs, no ba_rd pulse.
REQ-037 All four slots miss simultaneously, last_grant=3 -> service order 0,1,2,3; next simultaneous misses after slot 1 served alone -> order starts at 2.
REQ-038 DW=8, addr 0x21 after fill of 0x20 with word 0x5A3C -> hit, no ba_rd, slot_data 0x5A; addr 0x20 -> 0x3C.
REQ-039 downloading pulse after fills -> all slot_ok low; re-request -> fresh ba_rd.
REQ-040 rst asserted in DATA -> ba_rd 0 and slot_ok 0 immediately; late ba_rdy causes no cache write.
